// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pooling stage: raster-order pixels in,
// one pooled pixel per completed window out, valid/ready on both sides.
module maxpool2x2_stream #(
    parameter int BITWIDTH = 8,
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 10,
    parameter int HEIGHT   = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*BITWIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*BITWIDTH-1:0] out_data,
    output logic                         out_last
);

    localparam int PIX_W  = CHANNELS * BITWIDTH;
    localparam int HALF_W = WIDTH / 2;
    localparam int COL_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int ROW_W  = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("maxpool2x2_stream: WIDTH must be even and >= 2");
    end
    if ((HEIGHT < 2) || ((HEIGHT % 2) != 0)) begin : g_bad_height
        $error("maxpool2x2_stream: HEIGHT must be even and >= 2");
    end

    // Per-channel signed max; on a tie the first operand is kept.
    function automatic logic [PIX_W-1:0] pix_max(input logic [PIX_W-1:0] first,
                                                 input logic [PIX_W-1:0] second);
        logic [PIX_W-1:0]           res;
        logic signed [BITWIDTH-1:0] a_ch;
        logic signed [BITWIDTH-1:0] b_ch;
        res = first;
        for (int c = 0; c < CHANNELS; c++) begin
            a_ch = first[c*BITWIDTH +: BITWIDTH];
            b_ch = second[c*BITWIDTH +: BITWIDTH];
            if (b_ch > a_ch) begin
                res[c*BITWIDTH +: BITWIDTH] = b_ch;
            end
        end
        return res;
    endfunction

    logic [COL_W-1:0] col_p0;
    logic [ROW_W-1:0] row_p0;
    logic [PIX_W-1:0] h_p0;
    logic [PIX_W-1:0] line_p0 [HALF_W];

    logic [PIX_W-1:0] res_p1;
    logic             vld_p1;
    logic             last_p1;

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             produce;
    logic [LB_AW-1:0] lb_idx;
    logic [PIX_W-1:0] hm;
    logic [PIX_W-1:0] pooled;

    assign in_ready  = !vld_p1 || out_ready;
    assign accept    = in_valid && in_ready;
    assign col_last  = (col_p0 == COL_W'(WIDTH - 1));
    assign row_last  = (row_p0 == ROW_W'(HEIGHT - 1));
    assign lb_idx    = LB_AW'(col_p0 >> 1);
    assign hm        = pix_max(h_p0, in_data);
    assign pooled    = pix_max(line_p0[lb_idx], hm);
    assign produce   = accept && col_p0[0] && row_p0[0];

    assign out_valid = vld_p1;
    assign out_data  = res_p1;
    assign out_last  = last_p1;

    // Stage p0: raster position of the next accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_p0 <= '0;
            row_p0 <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_p0 <= '0;
                row_p0 <= row_last ? '0 : row_p0 + ROW_W'(1);
            end else begin
                col_p0 <= col_p0 + COL_W'(1);
            end
        end
    end

    // Partial maxima; every entry is written before it is read in a frame.
    always_ff @(posedge clk) begin
        if (accept && !col_p0[0]) begin
            h_p0 <= in_data;
        end
        if (accept && col_p0[0] && !row_p0[0]) begin
            line_p0[lb_idx] <= hm;
        end
    end

    // Stage p1: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            res_p1  <= '0;
        end else if (produce) begin
            vld_p1  <= 1'b1;
            last_p1 <= col_last && row_last;
            res_p1  <= pooled;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: a 4x4 instance for the directed scenarios and a
// default 10x10 instance for a random frame, both against a window-max model.
module tb_maxpool2x2_stream;

    logic clk;
    logic rst_n;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_in_data;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [15:0] s_out_data;
    logic        s_out_last;

    logic        l_in_valid;
    logic        l_in_ready;
    logic [15:0] l_in_data;
    logic        l_out_valid;
    logic        l_out_ready;
    logic [15:0] l_out_data;
    logic        l_out_last;

    int nchk = 0;
    int nerr = 0;
    int gap_max = 0;
    bit bp_en = 1'b0;
    int bp_ph = 0;

    logic [15:0] frame_q [$];
    logic [16:0] exp_q [$];
    logic [16:0] got_s [$];
    logic [16:0] got_l [$];

    localparam logic [15:0] BASIC_EXP [4] = '{16'h0005, 16'hFE07, 16'hF80D, 16'hF60F};

    maxpool2x2_stream #(.BITWIDTH(8), .CHANNELS(2), .WIDTH(4), .HEIGHT(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_last(s_out_last)
    );

    maxpool2x2_stream #(.BITWIDTH(8), .CHANNELS(2), .WIDTH(10), .HEIGHT(10)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
        .out_last(l_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready pattern 1,0,0,1 while backpressure is enabled.
    always @(posedge clk) begin
        if (bp_en) begin
            s_out_ready <= (bp_ph == 0) || (bp_ph == 3);
            bp_ph       <= (bp_ph + 1) % 4;
        end else begin
            s_out_ready <= 1'b1;
            bp_ph       <= 0;
        end
    end

    always @(negedge clk) begin
        if (s_out_valid && s_out_ready) got_s.push_back({s_out_last, s_out_data});
        if (l_out_valid && l_out_ready) got_l.push_back({l_out_last, l_out_data});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required less", $time);
        $fatal(1, "watchdog");
    end

    // Reference: max of each 2x2 window, computed directly on the raster frame.
    function automatic void model(input int w, input int h, input int base);
        logic [15:0] p;
        logic [15:0] o;
        int          m;
        int          v;
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                o = '0;
                for (int ch = 0; ch < 2; ch++) begin
                    m = -100000;
                    for (int dy = 0; dy < 2; dy++) begin
                        for (int dx = 0; dx < 2; dx++) begin
                            p = frame_q[base + (2 * r + dy) * w + 2 * c + dx];
                            v = int'($signed(p[ch*8 +: 8]));
                            if (v > m) m = v;
                        end
                    end
                    o[ch*8 +: 8] = m[7:0];
                end
                exp_q.push_back({(r == h / 2 - 1) && (c == w / 2 - 1), o});
            end
        end
    endfunction

    function automatic logic [15:0] basic_pix(input int i);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(i);
        b = 8'(-i);
        return {b, a};
    endfunction

    task automatic idle_gap();
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic push_s(input logic [15:0] d);
        int n;
        bit acc;
        idle_gap();
        s_in_data  = d;
        s_in_valid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_in_valid = 1'b0;
        if (!acc) begin
            nchk++;
            nerr++;
            $display("FAIL push_s_timeout: beat %h not accepted after %0d cycles, required acceptance", d, n);
        end
    endtask

    task automatic push_l(input logic [15:0] d);
        int n;
        bit acc;
        idle_gap();
        l_in_data  = d;
        l_in_valid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = l_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        l_in_valid = 1'b0;
        if (!acc) begin
            nchk++;
            nerr++;
            $display("FAIL push_l_timeout: beat %h not accepted after %0d cycles, required acceptance", d, n);
        end
    endtask

    task automatic drain();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nchk++; if (s_out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b, required 0", s_out_valid); end
        nchk++; if (s_out_last !== 1'b0) begin nerr++; $display("FAIL reset_out_last: got %b, required 0", s_out_last); end
        nchk++; if (s_out_data !== 16'h0000) begin nerr++; $display("FAIL reset_out_data: got %h, required 0000", s_out_data); end
        nchk++; if (l_out_valid !== 1'b0) begin nerr++; $display("FAIL reset_l_out_valid: got %b, required 0", l_out_valid); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nchk++; if (s_in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b, required 1", s_in_ready); end
        nchk++; if (l_in_ready !== 1'b1) begin nerr++; $display("FAIL reset_l_in_ready: got %b, required 1", l_in_ready); end
    endtask

    task automatic test_basic();
        logic [16:0] e;
        got_s.delete();
        for (int i = 0; i < 16; i++) push_s(basic_pix(i));
        drain();
        nchk++;
        if (got_s.size() != 4) begin nerr++; $display("FAIL basic_count: got %0d outputs, required 4", got_s.size()); end
        for (int i = 0; i < 4; i++) begin
            e = {(i == 3), BASIC_EXP[i]};
            nchk++;
            if (i >= got_s.size()) begin
                nerr++; $display("FAIL basic_out%0d: missing, required %h", i, e);
            end else if (got_s[i] !== e) begin
                nerr++; $display("FAIL basic_out%0d: got %h, required %h", i, got_s[i], e);
            end
        end
    endtask

    task automatic test_signed_extremes();
        int          ch0 [16];
        logic [15:0] p;
        logic [7:0]  b0;
        logic [7:0]  q;
        logic [7:0]  ext_exp [3];
        ch0 = '{-128, -1, 127, -128,
                -128, -128, 0, 0,
                -128, -128, 3, -7,
                -128, -128, 44, -100};
        ext_exp = '{8'hFF, 8'h7F, 8'h80};
        frame_q.delete();
        exp_q.delete();
        got_s.delete();
        for (int i = 0; i < 16; i++) begin
            b0 = 8'(ch0[i]);
            q  = 8'($urandom);
            frame_q.push_back({q, b0});
        end
        model(4, 4, 0);
        gap_max = 1;
        for (int i = 0; i < 16; i++) begin
            p = frame_q[i];
            push_s(p);
        end
        gap_max = 0;
        drain();
        nchk++;
        if (got_s.size() != 4) begin nerr++; $display("FAIL extremes_count: got %0d outputs, required 4", got_s.size()); end
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (i >= got_s.size()) begin
                nerr++; $display("FAIL extremes_ch0_out%0d: missing, required %h", i, ext_exp[i]);
            end else if (got_s[i][7:0] !== ext_exp[i]) begin
                nerr++; $display("FAIL extremes_ch0_out%0d: got %h, required %h", i, got_s[i][7:0], ext_exp[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            nchk++;
            if (i >= got_s.size()) begin
                nerr++; $display("FAIL extremes_out%0d: missing, required %h", i, exp_q[i]);
            end else if (got_s[i] !== exp_q[i]) begin
                nerr++; $display("FAIL extremes_out%0d: got %h, required %h", i, got_s[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit          done;
        logic [16:0] e;
        got_s.delete();
        gap_max = 2;
        bp_en   = 1'b1;
        done    = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) push_s(basic_pix(i));
                repeat (30) @(posedge clk);
                #1;
                done = 1'b1;
            end
            begin
                bit          prev_stall;
                bit          exp_rdy;
                logic [15:0] prev_d;
                prev_stall = 1'b0;
                prev_d     = '0;
                while (!done) begin
                    @(negedge clk);
                    exp_rdy = !(s_out_valid && !s_out_ready);
                    nchk++;
                    if (s_in_ready !== exp_rdy) begin
                        nerr++; $display("FAIL bp_in_ready: got %b, required %b", s_in_ready, exp_rdy);
                    end
                    if (prev_stall) begin
                        nchk++;
                        if (s_out_valid !== 1'b1 || s_out_data !== prev_d) begin
                            nerr++; $display("FAIL bp_stall_hold: got valid %b data %h, required valid 1 data %h",
                                             s_out_valid, s_out_data, prev_d);
                        end
                    end
                    prev_stall = s_out_valid && !s_out_ready;
                    prev_d     = s_out_data;
                end
            end
        join
        bp_en   = 1'b0;
        gap_max = 0;
        drain();
        nchk++;
        if (got_s.size() != 4) begin nerr++; $display("FAIL bp_count: got %0d outputs, required 4", got_s.size()); end
        for (int i = 0; i < 4; i++) begin
            e = {(i == 3), BASIC_EXP[i]};
            nchk++;
            if (i >= got_s.size()) begin
                nerr++; $display("FAIL bp_out%0d: missing, required %h", i, e);
            end else if (got_s[i] !== e) begin
                nerr++; $display("FAIL bp_out%0d: got %h, required %h", i, got_s[i], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        frame_q.delete();
        exp_q.delete();
        got_s.delete();
        for (int i = 0; i < 16; i++) frame_q.push_back(basic_pix(i));
        for (int i = 0; i < 16; i++) frame_q.push_back(16'($urandom));
        model(4, 4, 0);
        model(4, 4, 16);
        for (int i = 0; i < 32; i++) begin
            p = frame_q[i];
            push_s(p);
        end
        drain();
        nchk++;
        if (got_s.size() != 8) begin nerr++; $display("FAIL b2b_count: got %0d outputs, required 8", got_s.size()); end
        for (int i = 0; i < 8; i++) begin
            nchk++;
            if (i >= got_s.size()) begin
                nerr++; $display("FAIL b2b_out%0d: missing, required %h", i, exp_q[i]);
            end else if (got_s[i] !== exp_q[i]) begin
                nerr++; $display("FAIL b2b_out%0d: got %h, required %h", i, got_s[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [16:0] e;
        got_s.delete();
        for (int i = 0; i < 6; i++) push_s(16'($urandom));
        rst_n = 1'b0;
        #1;
        nchk++; if (s_out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_out_valid: got %b, required 0", s_out_valid); end
        nchk++; if (s_out_last !== 1'b0) begin nerr++; $display("FAIL midrst_out_last: got %b, required 0", s_out_last); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) push_s(basic_pix(i));
        drain();
        nchk++;
        if (got_s.size() != 4) begin nerr++; $display("FAIL midrst_count: got %0d outputs, required 4", got_s.size()); end
        for (int i = 0; i < 4; i++) begin
            e = {(i == 3), BASIC_EXP[i]};
            nchk++;
            if (i >= got_s.size()) begin
                nerr++; $display("FAIL midrst_out%0d: missing, required %h", i, e);
            end else if (got_s[i] !== e) begin
                nerr++; $display("FAIL midrst_out%0d: got %h, required %h", i, got_s[i], e);
            end
        end
    endtask

    task automatic test_default_random();
        logic [15:0] p;
        frame_q.delete();
        exp_q.delete();
        got_l.delete();
        for (int i = 0; i < 100; i++) frame_q.push_back(16'($urandom));
        model(10, 10, 0);
        gap_max = 1;
        for (int i = 0; i < 100; i++) begin
            p = frame_q[i];
            push_l(p);
        end
        gap_max = 0;
        drain();
        nchk++;
        if (got_l.size() != 25) begin nerr++; $display("FAIL default_count: got %0d outputs, required 25", got_l.size()); end
        for (int i = 0; i < 25; i++) begin
            nchk++;
            if (i >= got_l.size()) begin
                nerr++; $display("FAIL default_out%0d: missing, required %h", i, exp_q[i]);
            end else if (got_l[i] !== exp_q[i]) begin
                nerr++; $display("FAIL default_out%0d: got %h, required %h", i, got_l[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        l_in_valid  = 1'b0;
        l_in_data   = '0;
        l_out_ready = 1'b1;
        test_reset();
        test_basic();
        test_signed_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_default_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
